// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: pushbutton command generator for a clocked SR flip-flop stage.
// Each debounced press of set_btn / clr_btn becomes one PULSE_LEN-cycle pulse
// on s or r. The pulse is followed by a one-cycle CHECK that compares q_fb
// with the commanded value. s and r come from a single one-hot state decode,
// so they can never be high together.

// Per-button conditioning: 2-flop synchroniser, debounce counter and
// rising-edge detector on the debounced level.
module sr_cmd_gen_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic req
);

    localparam logic [7:0] DEB_LIM = 8'(DEB_CYCLES);

    logic       sync1_r;
    logic       sync2_r;
    logic       level_r;
    logic       level_d_r;
    logic [7:0] cnt_r;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: the level flips only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            cnt_r   <= 8'd0;
        end else if (cnt_r == DEB_LIM) begin
            level_r <= ~level_r;
            cnt_r   <= 8'd0;
        end else if (sync2_r != level_r) begin
            cnt_r   <= cnt_r + 8'd1;
        end else begin
            cnt_r   <= 8'd0;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
        end
    end

    // Request is a single cycle on the debounced rising edge; falling edges are ignored.
    assign req = level_r & ~level_d_r;

endmodule

// Top level: two conditioned buttons feeding the command FSM.
module sr_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_btn,
    input  logic       clr_btn,
    input  logic       q_fb,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic       mismatch,
    output logic [7:0] evt_cnt
);

    localparam logic [3:0] PULSE_LIM = 4'(PULSE_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        CHECK   = 2'd3
    } state_t;

    logic       set_req_s;
    logic       clr_req_s;

    state_t     state_r;
    state_t     state_nx_s;
    logic [3:0] pcnt_r;
    logic [3:0] pcnt_nx_s;
    logic [7:0] evt_r;
    logic [7:0] evt_nx_s;
    logic       conflict_r;
    logic       conflict_nx_s;
    logic       mismatch_r;
    logic       mismatch_nx_s;
    logic       exp_q_r;
    logic       exp_q_nx_s;
    logic       cmd_s_r;
    logic       cmd_r_r;
    logic       busy_r;

    sr_cmd_gen_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (set_btn),
        .req   (set_req_s)
    );

    sr_cmd_gen_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (clr_btn),
        .req   (clr_req_s)
    );

    // Next-state logic; requests are only honoured in IDLE, elsewhere they are dropped.
    always_comb begin
        state_nx_s    = state_r;
        pcnt_nx_s     = pcnt_r;
        evt_nx_s      = evt_r;
        conflict_nx_s = conflict_r;
        mismatch_nx_s = mismatch_r;
        exp_q_nx_s    = exp_q_r;
        case (state_r)
            IDLE: begin
                if (set_req_s && !clr_req_s) begin
                    state_nx_s = PULSE_S;
                    pcnt_nx_s  = PULSE_LIM;
                    evt_nx_s   = evt_r + 8'd1;
                    exp_q_nx_s = 1'b1;
                end else if (clr_req_s && !set_req_s) begin
                    state_nx_s = PULSE_R;
                    pcnt_nx_s  = PULSE_LIM;
                    evt_nx_s   = evt_r + 8'd1;
                    exp_q_nx_s = 1'b0;
                end else if (set_req_s && clr_req_s) begin
                    conflict_nx_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PULSE_S, PULSE_R: begin
                if (pcnt_r <= 4'd1) begin
                    state_nx_s = CHECK;
                    pcnt_nx_s  = 4'd0;
                end else begin
                    pcnt_nx_s  = pcnt_r - 4'd1;
                end
            end
            CHECK: begin
                state_nx_s = IDLE;
                if (q_fb != exp_q_r) begin
                    mismatch_nx_s = 1'b1;
                end else begin
                    mismatch_nx_s = mismatch_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
                pcnt_nx_s  = 4'd0;
            end
        endcase
    end

    // State, counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pcnt_r     <= 4'd0;
            evt_r      <= 8'd0;
            conflict_r <= 1'b0;
            mismatch_r <= 1'b0;
            exp_q_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            pcnt_r     <= pcnt_nx_s;
            evt_r      <= evt_nx_s;
            conflict_r <= conflict_nx_s;
            mismatch_r <= mismatch_nx_s;
            exp_q_r    <= exp_q_nx_s;
        end
    end

    // Registered command outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_s_r <= 1'b0;
            cmd_r_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            cmd_s_r <= (state_nx_s == PULSE_S);
            cmd_r_r <= (state_nx_s == PULSE_R);
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    assign s        = cmd_s_r;
    assign r        = cmd_r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;
    assign mismatch = mismatch_r;
    assign evt_cnt  = evt_r;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: a directed table, several hand-written sequences and a
// random phase. Every cycle is compared with an event-level reference model.
module tb_sr_cmd_gen;

    localparam int DEB = 4;
    localparam int PL  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_btn = 1'b0;
    logic       clr_btn = 1'b0;
    logic       q_fb;
    logic       s, r, busy, conflict, mismatch;
    logic [7:0] evt_cnt;

    logic       ff_q = 1'b0;
    logic       fen = 1'b0;
    logic       fval = 1'b0;

    int checks = 0;
    int failures = 0;
    int sr_overlap = 0;
    int s_rises, r_rises, pulse_cyc, busy_cyc, lat;

    assign q_fb = fen ? fval : ff_q;

    sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_LEN(PL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_btn  (set_btn),
        .clr_btn  (clr_btn),
        .q_fb     (q_fb),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict),
        .mismatch (mismatch),
        .evt_cnt  (evt_cnt)
    );

    always #5 clk = ~clk;

    always @(s, r) if (s && r) sr_overlap++;

    // Reference model state. Time is counted in clock edges since reset release.
    int         m_k;
    bit         m_lvl [2];
    int         m_flip [2];
    bit         m_rp [2];
    int         m_next_ok;
    int         m_acc;
    bit         m_kind_s;
    bit         m_has;
    logic [7:0] m_evt;
    bit         m_conf, m_mis;
    bit         hist_s [$];
    bit         hist_c [$];
    bit         e_s, e_r, e_busy;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Debouncer input seen at edge j is the button sampled two edges earlier.
    function automatic bit cons(input int b, input int j);
        if (j < 2) return 1'b0;
        return (b == 0) ? hist_s[j-2] : hist_c[j-2];
    endfunction

    task automatic model_reset();
        m_k = 0;
        m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
        m_flip[0] = -1000; m_flip[1] = -1000;
        m_rp[0] = 1'b0; m_rp[1] = 1'b0;
        m_next_ok = 0; m_acc = -1000; m_kind_s = 1'b0; m_has = 1'b0;
        m_evt = 8'd0; m_conf = 1'b0; m_mis = 1'b0;
        hist_s.delete(); hist_c.delete();
        e_s = 1'b0; e_r = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_step(input bit sb, input bit cb, input bit qpre);
        bit flip;
        bit rise [2];
        bit req0, req1;
        req0 = m_rp[0];
        req1 = m_rp[1];
        for (int b = 0; b < 2; b++) begin
            // Level flips once DEB samples in a row (since the last flip) disagree with it.
            flip = (m_k - m_flip[b] >= DEB + 1);
            for (int j = m_k - DEB; j < m_k; j++) if (cons(b, j) == m_lvl[b]) flip = 1'b0;
            rise[b] = flip && !m_lvl[b];
            if (flip) begin
                m_lvl[b] = !m_lvl[b];
                m_flip[b] = m_k;
            end
        end
        hist_s.push_back(sb);
        hist_c.push_back(cb);
        if (m_has && m_k == m_acc + PL + 1) begin
            if (qpre != m_kind_s) m_mis = 1'b1;
            m_has = 1'b0;
        end
        if (m_k >= m_next_ok) begin
            if (req0 && req1) m_conf = 1'b1;
            else if (req0 || req1) begin
                m_acc = m_k; m_kind_s = req0; m_has = 1'b1;
                m_evt = m_evt + 8'd1; m_next_ok = m_k + PL + 2;
            end
        end
        e_s    = m_has && m_kind_s && m_k >= m_acc && m_k <= m_acc + PL - 1;
        e_r    = m_has && !m_kind_s && m_k >= m_acc && m_k <= m_acc + PL - 1;
        e_busy = m_has && m_k <= m_acc + PL;
        m_rp[0] = rise[0];
        m_rp[1] = rise[1];
        m_k++;
    endtask

    task automatic tick(input bit sb, input bit cb);
        bit ps, pr, pq;
        set_btn = sb;
        clr_btn = cb;
        ps = s; pr = r; pq = q_fb;
        @(posedge clk);
        #1;
        if (ps) ff_q = 1'b1;
        else if (pr) ff_q = 1'b0;
        model_step(sb, cb, pq);
        if (s && !ps) s_rises++;
        if (r && !pr) r_rises++;
        if (s || r) pulse_cyc++;
        if (busy) busy_cyc++;
        check("cycle_model", int'({s, r, busy, conflict, mismatch, evt_cnt}),
              int'({e_s, e_r, e_busy, m_conf, m_mis, m_evt}));
    endtask

    task automatic do_reset(input bit sb, input bit cb);
        set_btn = sb;
        clr_btn = cb;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({s, r, busy, conflict, mismatch, evt_cnt}), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic clr_stats();
        s_rises = 0; r_rises = 0; pulse_cyc = 0; busy_cyc = 0; lat = -1;
    endtask

    typedef struct {
        bit rst;
        bit sb;
        bit cb;
        bit fen;
        bit fval;
        int evt_delta;
        int s_pulses;
        int r_pulses;
        int pulse_cycles;
        int busy_cycles;
        int latency;
        bit conf;
        bit mis;
    } vec_t;

    vec_t vecs [6];
    bit   bpat [5];
    int   row_evt;
    int   hold_s, hold_c;
    bit   cur_s, cur_c;

    initial begin
        //          rst   set   clr   fen   fval  dEvt sP rP pCyc bCyc lat conf mis
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0, 2, 3, 7,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 2, 3, 7,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, -1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1, 2, 3, 7,  1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 0, 2, 3, 7,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 0, 2, 3, 7,  1'b0, 1'b0};
        row_evt = 0;
        model_reset();

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rst) begin
                do_reset(1'b0, 1'b0);
                row_evt = 0;
            end
            fen = vecs[v].fen;
            fval = vecs[v].fval;
            clr_stats();
            for (int i = 0; i < 32; i++) begin
                tick((i < 20) ? vecs[v].sb : 1'b0, (i < 20) ? vecs[v].cb : 1'b0);
                if (lat < 0 && (s || r)) lat = i;
            end
            row_evt = row_evt + vecs[v].evt_delta;
            check("row_s_pulses", s_rises, vecs[v].s_pulses);
            check("row_r_pulses", r_rises, vecs[v].r_pulses);
            check("row_pulse_cycles", pulse_cyc, vecs[v].pulse_cycles);
            check("row_busy_cycles", busy_cyc, vecs[v].busy_cycles);
            check("row_latency", lat, vecs[v].latency);
            check("row_conflict", int'(conflict), int'(vecs[v].conf));
            check("row_mismatch", int'(mismatch), int'(vecs[v].mis));
            check("row_evt_cnt", int'(evt_cnt), row_evt % 256);
            fen = 1'b0;
        end

        // Bouncing set press: one pulse, timed from the stable-high run (tick 4).
        do_reset(1'b0, 1'b0);
        bpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        clr_stats();
        for (int i = 0; i < 30; i++) begin
            tick((i < 5) ? bpat[i] : (i < 20), 1'b0);
            if (lat < 0 && s) lat = i;
        end
        check("bounce_s_pulses", s_rises, 1);
        check("bounce_latency", lat, 4 + DEB + 3);

        // Short bounce (below DEB_CYCLES) never produces a request.
        clr_stats();
        for (int i = 0; i < 20; i++) tick(i < DEB - 1, 1'b0);
        check("short_bounce_no_pulse", s_rises + r_rises, 0);

        // Clear press arriving while the set pulse is in flight is dropped.
        do_reset(1'b0, 1'b0);
        clr_stats();
        for (int i = 0; i < 32; i++) tick(i < 20, (i >= 1) && (i < 20));
        check("drop_s_pulses", s_rises, 1);
        check("drop_r_pulses", r_rises, 0);
        check("drop_evt_cnt", int'(evt_cnt), 1);
        check("drop_conflict", int'(conflict), 0);

        // Button held through reset release gives exactly one command.
        do_reset(1'b1, 1'b0);
        clr_stats();
        for (int i = 0; i < 32; i++) tick(i < 20, 1'b0);
        check("held_reset_s_pulses", s_rises, 1);
        check("held_reset_evt_cnt", int'(evt_cnt), 1);

        // Reset mid-pulse: outputs drop without waiting for a clock edge.
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            if (s) break;
        end
        check("midpulse_s_high", int'(s), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({s, r, busy, conflict, mismatch, evt_cnt}), 0);
        do_reset(1'b0, 1'b0);

        // 256 accepted commands wrap evt_cnt back to 0.
        for (int c = 0; c < 256; c++) begin
            for (int i = 0; i < 12; i++) tick(c % 2 == 0, c % 2 == 1);
            for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
            if (c == 254) check("evt_cnt_255", int'(evt_cnt), 255);
        end
        check("evt_cnt_wrap", int'(evt_cnt), 0);
        check("wrap_mismatch", int'(mismatch), 0);

        // Random buttons and occasional forced feedback against the model.
        do_reset(1'b0, 1'b0);
        hold_s = 0; hold_c = 0; cur_s = 1'b0; cur_c = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (hold_s == 0) begin
                cur_s = 1'($urandom_range(0, 1));
                hold_s = int'($urandom_range(1, 12));
            end
            if (hold_c == 0) begin
                cur_c = 1'($urandom_range(0, 1));
                hold_c = int'($urandom_range(1, 12));
            end
            if (t % 400 == 0) begin
                fen = 1'($urandom_range(0, 1));
                fval = 1'($urandom_range(0, 1));
            end
            tick(cur_s, cur_c);
            hold_s--;
            hold_c--;
        end
        fen = 1'b0;

        check("s_and_r_exclusive", sr_overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command generator for the clocked SR flip-flop stage. Takes two raw pushbutton inputs (set, clear), synchronises and debounces them, and converts each press into a single fixed-width `s` or `r` pulse. It guarantees that `s` and `r` are never high together. It reads the flip-flop's `q` back and flags commands that did not take effect.

## Interface

Parameters:
- `DEB_CYCLES`, default 4: consecutive stable samples required before a debounced level changes (legal range 2–255).
- `PULSE_LEN`, default 2: number of clock cycles `s`/`r` is held high per command (legal range 1–15).

Ports:
- `clk`, in, 1: single system clock; all state is updated on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `set_btn`, in, 1: raw set pushbutton, asynchronous and may bounce.
- `clr_btn`, in, 1: raw clear pushbutton, asynchronous and may bounce.
- `q_fb`, in, 1: `q` fed back from the SR flip-flop stage.
- `s`, out, 1: set command to the flip-flop.
- `r`, out, 1: reset command to the flip-flop.
- `busy`, out, 1: high while a command is in flight.
- `conflict`, out, 1: sticky; set when a set and a clear request arrive in the same cycle.
- `mismatch`, out, 1: sticky; set when `q_fb` does not match the commanded value.
- `evt_cnt`, out, 8: count of accepted commands; wraps from 255 to 0.

## Operation

Input conditioning (per button, identical logic):
- A 2-flop synchroniser feeds a debounce counter.
- When the synchronised sample differs from the debounced level, the counter increments. When it equals the debounced level, the counter clears.
- When the counter reaches `DEB_CYCLES`, the debounced level toggles and the counter clears.
- A rising edge of the debounced level produces a one-cycle request (`set_req` / `clr_req`). Falling edges produce nothing.

FSM states are IDLE, PULSE_S, PULSE_R and CHECK.
- IDLE:
  - `set_req` and not `clr_req`: go to PULSE_S.
  - `clr_req` and not `set_req`: go to PULSE_R.
  - Both together: set `conflict`, stay in IDLE, issue no command.
- Entering PULSE_S or PULSE_R: increment `evt_cnt` and load the pulse counter with `PULSE_LEN`.
- PULSE_S / PULSE_R:
  - Drive `s=1` (or `r=1`) and decrement the counter.
  - Go to CHECK after exactly `PULSE_LEN` cycles in the state.
  - Any `set_req`/`clr_req` arriving in these states is dropped and not queued.
- CHECK:
  - Lasts one cycle with `s=r=0`.
  - Sample `q_fb`: expected value is 1 after PULSE_S and 0 after PULSE_R. A difference sets `mismatch`.
  - Return to IDLE.
  - A request arriving during CHECK is dropped.
- `busy` is 1 in PULSE_S, PULSE_R and CHECK, and 0 in IDLE.
- Invariant: `s & r` is never 1, including during reset and at state transitions.
- `conflict` and `mismatch` stay set until the next `rst_n` assertion; nothing else clears them.

## Timing

- All outputs are registered.
- Reset values: `s=0`, `r=0`, `busy=0`, `conflict=0`, `mismatch=0`, `evt_cnt=0`, state IDLE. Synchroniser flops, debounced levels and all counters are also 0.
- Reset asserted mid-pulse: `s`/`r` drop to 0 asynchronously and immediately. No CHECK is performed and `evt_cnt` is cleared.
- A button still held high when `rst_n` releases debounces from 0 and produces exactly one request.
- Latency: a clean input change first sampled at edge E0 drives `s`/`r` high after edge E0 + `DEB_CYCLES` + 3. The three extra edges are 2 for the synchroniser and 1 for edge detect/FSM.
- Command occupancy is `PULSE_LEN` + 1 cycles. The earliest next command is accepted on the cycle after CHECK.
- Bounce shorter than `DEB_CYCLES` cycles produces no request.

## Test plan

- Reset then clean set press, held 20 cycles, `DEB_CYCLES=4`, `PULSE_LEN=2`, `q_fb` tied to a model flip-flop:
  - `s` rises 7 cycles after the first sampling edge and stays high exactly 2 cycles.
  - `busy` is high for 3 cycles and `evt_cnt=1`.
  - `mismatch=0`, `r` stays 0.
- Set press with bounce (set_btn toggles 1/0/1/0/1 on successive cycles, then held high):
  - Exactly one `s` pulse results, timed from the start of the stable-high run.
- Set and clear pressed on the same edge, both clean:
  - `conflict` goes to 1, `s=r=0` throughout, `evt_cnt` unchanged.
- Clear command with `q_fb` forced to 1:
  - `r` pulses for 2 cycles, then `mismatch` goes to 1 in CHECK and stays 1.
- Second press arriving during PULSE_S:
  - The second press is dropped: one `s` pulse only, `evt_cnt` incremented by exactly 1.
- Additional checks:
  - `rst_n` low mid-pulse forces `s` to 0 without waiting for a clock edge, and all flags and `evt_cnt` read 0.
  - 256 accepted commands bring `evt_cnt` back to 0.
  - The assertion `!(s && r)` holds for the whole run.
